// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI ADC target model: conversion frames from a sample buffer plus a 24-bit register-mode command path.
// Optional error counter in status[15:8] is compiled in with ADC_RESP_ERR_CNT_EN.
module adc_spi_responder #(
  parameter int NUM_SDI    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  spi_sck,
  input  logic                  spi_csn,
  input  logic                  spi_mosi,
  output logic [NUM_SDI-1:0]    spi_miso,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [31:0]           status
);

  localparam int BEATS    = DATA_WIDTH / NUM_SDI;
  localparam int CMD_BITS = 24;
  localparam int CNT_MAX  = (BEATS > CMD_BITS) ? BEATS : CMD_BITS;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0] CMD_C   = CW'(CMD_BITS);
  localparam logic [CW-1:0] MAX_C   = CW'(CNT_MAX);
  localparam logic [23:0]   EXIT_CMD = 24'h801401;

  typedef enum logic [1:0] {
    IDLE,
    CNV_FRAME,
    REG_FRAME
  } state_t;

  state_t state, state_d;

  logic [2:0] sck_q;
  logic [2:0] csn_q;
  logic [1:0] mosi_q;

  logic sck_rise, sck_fall, csn_rise, csn_fall, mosi_s;

  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         cnt_lim;
  logic [23:0]           rx;
  logic [7:0]            rd_shift;
  logic [7:0]            rd_byte;
  logic [7:0]            regfile [16];
  logic                  reg_mode;
  logic                  underrun;
  logic                  aborted;
  logic [15:0]           last_cmd;
  logic [7:0]            err_cnt;

  logic cnv_start, reg_start, cmd_done, frame_abort;

  // csn synchronizer resets to "low" so a frame already in progress at reset
  // release produces no falling edge; the spurious rising edge lands in IDLE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sck_q  <= '0;
      csn_q  <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      csn_q  <= {csn_q[1:0], spi_csn};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign csn_rise = csn_q[1] & ~csn_q[2];
  assign csn_fall = ~csn_q[1] & csn_q[2];
  assign mosi_s   = mosi_q[1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d     = state;
    cnv_start   = 1'b0;
    reg_start   = 1'b0;
    cmd_done    = 1'b0;
    frame_abort = 1'b0;
    case (state)
      IDLE: begin
        if (csn_fall) begin
          if (reg_mode) begin
            state_d   = REG_FRAME;
            reg_start = 1'b1;
          end else begin
            state_d   = CNV_FRAME;
            cnv_start = 1'b1;
          end
        end
      end
      CNV_FRAME: begin
        if (csn_rise) begin
          state_d = IDLE;
          if (bit_cnt < BEATS_C)     frame_abort = 1'b1;
          else if (bit_cnt >= CMD_C) cmd_done    = 1'b1;
        end
      end
      REG_FRAME: begin
        if (csn_rise) begin
          state_d = IDLE;
          if (bit_cnt != CMD_C) frame_abort = 1'b1;
          else                  cmd_done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A conversion frame long enough to carry 24 bits can also deliver the
  // register-mode entry command, so both frame types capture mosi.
  assign cnt_lim = (state == REG_FRAME) ? CMD_C : MAX_C;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      rx        <= '0;
      rd_shift  <= '0;
      rd_byte   <= '0;
      reg_mode  <= 1'b0;
      underrun  <= 1'b0;
      aborted   <= 1'b0;
      last_cmd  <= '0;
      for (int i = 0; i < 16; i++) regfile[i] <= '0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        buf_data  <= s_axis_tdata;
        buf_valid <= 1'b1;
      end else if (cnv_start) begin
        buf_valid <= 1'b0;
      end

      if (cnv_start) begin
        shift <= buf_valid ? buf_data : '0;
        if (!buf_valid) underrun <= 1'b1;
      end else if (state == CNV_FRAME && sck_fall) begin
        shift <= shift << NUM_SDI;
      end

      if (cnv_start || reg_start) begin
        bit_cnt  <= '0;
        rx       <= '0;
        rd_shift <= reg_start ? rd_byte : 8'h00;
      end else if (state != IDLE) begin
        if (sck_rise && bit_cnt < cnt_lim) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt < CMD_C) rx <= {rx[22:0], mosi_s};
        end
        if (state == REG_FRAME && sck_fall) rd_shift <= {rd_shift[6:0], 1'b0};
      end

      if (frame_abort) aborted <= 1'b1;

      if (cmd_done) begin
        last_cmd <= rx[23:8];
        if (rx == EXIT_CMD) begin
          reg_mode <= 1'b0;
        end else if (rx[23:21] == 3'b101) begin
          reg_mode <= 1'b1;
        end else if (rx[23]) begin
          if (rx[22:12] == '0) regfile[rx[11:8]] <= rx[7:0];
        end else begin
          rd_byte <= (rx[22:12] == '0) ? regfile[rx[11:8]] : 8'h00;
        end
      end
    end
  end

`ifdef ADC_RESP_ERR_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                          err_cnt <= '0;
    else if (frame_abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

  always_comb begin
    spi_miso = '0;
    case (state)
      CNV_FRAME: spi_miso    = shift[DATA_WIDTH-1 -: NUM_SDI];
      REG_FRAME: spi_miso[0] = rd_shift[7];
      default:   spi_miso    = '0;
    endcase
  end

  assign s_axis_tready = ~buf_valid;

  assign status = {last_cmd, err_cnt, 3'b000, aborted, underrun, reg_mode,
                   buf_valid, (state != IDLE)};

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - directed vector bench for adc_spi_responder (NUM_SDI=4, DATA_WIDTH=32).
module tb_adc_spi_responder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [3:0]  spi_miso;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] status;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  adc_spi_responder #(.NUM_SDI(4), .DATA_WIDTH(32)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .spi_sck       (spi_sck),
    .spi_csn       (spi_csn),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .status        (status)
  );

  typedef struct {
    logic        push;
    logic [31:0] sample;
    int          rises;
    logic [23:0] cmd;
    logic        chk_cap;
    logic [31:0] exp_cap;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic [31:0] exp_status;
    logic        exp_tready;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_sample(input logic [31:0] d);
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  // Initiator samples miso just before each sck rise and changes mosi after each fall.
  task automatic spi_frame(input int rises, input logic [23:0] cmd,
                           output logic [31:0] cap, output logic [7:0] rd);
    logic [23:0] sh;
    sh  = cmd;
    cap = '0;
    rd  = '0;
    spi_mosi = sh[23];
    spi_csn  = 1'b0;
    #100;
    for (int i = 0; i < rises; i++) begin
      cap = {cap[27:0], spi_miso};
      if (i < 8) rd = {rd[6:0], spi_miso[0]};
      spi_sck = 1'b1;
      #60;
      spi_sck = 1'b0;
      sh = {sh[22:0], 1'b0};
      spi_mosi = sh[23];
      #60;
    end
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    #200;
  endtask

  logic [31:0] cap;
  logic [7:0]  rd;
  logic [7:0]  err_one, err_two;

  initial begin
`ifdef ADC_RESP_ERR_CNT_EN
    err_one = 8'd1;
    err_two = 8'd2;
`else
    err_one = 8'd0;
    err_two = 8'd0;
`endif

    //            push  sample        rises cmd        chk  exp_cap       chk  rd     status          tready
    vecs[0]  = '{1'b1, 32'hA5C31F08, 8,  24'h000000, 1'b1, 32'hA5C31F08, 1'b0, 8'h00, 32'h0000_0000, 1'b1};
    vecs[1]  = '{1'b0, 32'h0,        8,  24'h000000, 1'b1, 32'h00000000, 1'b0, 8'h00, 32'h0000_0008, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,        24, 24'hBFFF00, 1'b1, 32'h00000000, 1'b0, 8'h00, 32'hBFFF_000C, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,        24, 24'h80035A, 1'b0, 32'h0,        1'b1, 8'h00, 32'h8003_000C, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,        24, 24'h000300, 1'b0, 32'h0,        1'b1, 8'h00, 32'h0003_000C, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,        24, 24'h000000, 1'b0, 32'h0,        1'b1, 8'h5A, 32'h0000_000C, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,        24, 24'h8005C3, 1'b0, 32'h0,        1'b1, 8'h00, 32'h8005_000C, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,        24, 24'h000500, 1'b0, 32'h0,        1'b1, 8'h00, 32'h0005_000C, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,        24, 24'h002000, 1'b0, 32'h0,        1'b1, 8'hC3, 32'h0020_000C, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,        24, 24'h000300, 1'b0, 32'h0,        1'b1, 8'h00, 32'h0003_000C, 1'b1};
    vecs[10] = '{1'b1, 32'h12345678, 24, 24'h801401, 1'b0, 32'h0,        1'b1, 8'h5A, 32'h8014_000A, 1'b0};
    vecs[11] = '{1'b0, 32'h0,        8,  24'h000000, 1'b1, 32'h12345678, 1'b0, 8'h00, 32'h8014_0008, 1'b1};

    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    check("reset_status", status, 32'h0);
    check("reset_tready", {31'b0, s_axis_tready}, 32'h1);
    check("reset_miso", {28'b0, spi_miso}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].push) push_sample(vecs[i].sample);
      @(negedge aclk);
      spi_frame(vecs[i].rises, vecs[i].cmd, cap, rd);
      if (vecs[i].chk_cap) check($sformatf("vec%0d_capture", i), cap, vecs[i].exp_cap);
      if (vecs[i].chk_rd)  check($sformatf("vec%0d_readback", i), {24'b0, rd}, {24'b0, vecs[i].exp_rd});
      check($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
      check($sformatf("vec%0d_tready", i), {31'b0, s_axis_tready}, {31'b0, vecs[i].exp_tready});
      check($sformatf("vec%0d_miso_idle", i), {28'b0, spi_miso}, 32'h0);
    end

    // Aborted register write must leave regfile and mode untouched.
    spi_frame(24, 24'hBFFF00, cap, rd);
    check("abort_entry_status", status, 32'hBFFF_000C);
    spi_frame(10, 24'h8003FF, cap, rd);
    check("abort_reg_status", status, {16'hBFFF, err_one, 8'h1C});
    spi_frame(24, 24'h000300, cap, rd);
    check("abort_rd_prev", {24'b0, rd}, 32'h5A);
    spi_frame(24, 24'h000000, cap, rd);
    check("abort_reg3_kept", {24'b0, rd}, 32'h5A);
    spi_frame(24, 24'h801401, cap, rd);
    check("abort_exit_status", status, {16'h8014, err_one, 8'h18});
    spi_frame(3, 24'h000000, cap, rd);
    check("abort_cnv_status", status, {16'h8014, err_two, 8'h18});

    // Reset in the middle of a conversion frame.
    push_sample(32'hA5C31F08);
    @(negedge aclk);
    spi_csn = 1'b0;
    #100;
    cap = '0;
    for (int i = 0; i < 3; i++) begin
      cap = {cap[27:0], spi_miso};
      spi_sck = 1'b1;
      #60;
      spi_sck = 1'b0;
      #60;
    end
    check("midframe_partial", cap, 32'h00000A5C);
    aresetn = 1'b0;
    #1;
    check("midreset_miso", {28'b0, spi_miso}, 32'h0);
    check("midreset_status", status, 32'h0);
    check("midreset_tready", {31'b0, s_axis_tready}, 32'h1);
    #9;
    aresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #60;
      check($sformatf("postreset_miso%0d", i), {28'b0, spi_miso}, 32'h0);
      spi_sck = 1'b1;
      #60;
      spi_sck = 1'b0;
    end
    #60;
    spi_csn = 1'b1;
    #200;
    check("postreset_status", status, 32'h0);
    push_sample(32'hA5C31F08);
    @(negedge aclk);
    spi_frame(8, 24'h000000, cap, rd);
    check("postreset_capture", cap, 32'hA5C31F08);
    check("postreset_frame_status", status, 32'h0);
    check("postreset_tready", {31'b0, s_axis_tready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
